// File: rtl/afe_cfg_apb_bridge.sv
// APB3 slave to AFE cfg-bus initiator bridge: one cfg request per APB transfer, registered outputs.
// Optional request timeout with error response when AFE_CFG_BRIDGE_TIMEOUT_EN is defined.
module afe_cfg_apb_bridge #(
  parameter int APB_AWIDTH     = 12,
  parameter int CFG_AWIDTH     = 11,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_CNT_WIDTH   = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [APB_AWIDTH-1:0] apb_paddr_i,
  input  logic [31:0]           apb_pwdata_i,
  input  logic                  apb_pwrite_i,
  input  logic                  apb_psel_i,
  input  logic                  apb_penable_i,
  output logic [31:0]           apb_prdata_o,
  output logic                  apb_pready_o,
  output logic                  apb_pslverr_o,
  output logic [CFG_AWIDTH-1:0] cfg_addr_o,
  output logic [31:0]           cfg_wdata_o,
  output logic                  cfg_rwn_o,
  output logic                  cfg_valid_o,
  input  logic [31:0]           cfg_rdata_i,
  input  logic                  cfg_ready_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Byte address widened so the word slice exists even when the APB bus is narrower.
  localparam int PW = (APB_AWIDTH > CFG_AWIDTH + 2) ? APB_AWIDTH : CFG_AWIDTH + 2;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PW-1:0]         w_paddr_ext;
  logic                  w_setup;
  logic                  w_handshake;
  logic                  w_expire;
  logic                  w_unused;

  logic                  r_valid, w_valid_nxt;
  logic [CFG_AWIDTH-1:0] r_addr, w_addr_nxt;
  logic [31:0]           r_wdata, w_wdata_nxt;
  logic                  r_rwn, w_rwn_nxt;
  logic [31:0]           r_prdata, w_prdata_nxt;
  logic                  r_pready, w_pready_nxt;
  logic                  r_pslverr, w_pslverr_nxt;
  logic                  r_busy, w_busy_nxt;

  assign w_paddr_ext = PW'(apb_paddr_i);
  assign w_setup     = apb_psel_i & ~apb_penable_i;
  assign w_handshake = (r_state == S_REQ) & cfg_ready_i;

`ifdef AFE_CFG_BRIDGE_TIMEOUT_EN
  logic [TO_CNT_WIDTH-1:0] r_to_cnt;

  assign w_expire = (r_state == S_REQ) & ~cfg_ready_i &
                    (r_to_cnt == TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_unused = ^w_paddr_ext[1:0];

  // Timeout counter: cleared on accept, counts stalled REQ cycles, saturates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) && w_setup) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_REQ) && !cfg_ready_i && (r_to_cnt != {TO_CNT_WIDTH{1'b1}})) begin
      r_to_cnt <= r_to_cnt + TO_CNT_WIDTH'(1);
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end
`else
  assign w_expire = 1'b0;
  assign w_unused = ^{w_paddr_ext[1:0], 32'(TIMEOUT_CYCLES), 32'(TO_CNT_WIDTH)};
`endif

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 32'h0;
      r_rwn     <= 1'b1;
      r_prdata  <= 32'h0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_addr    <= w_addr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_rwn     <= w_rwn_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pready  <= w_pready_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  // Next-state logic; a setup with penable already high is ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) w_state_nxt = S_REQ;
        else         w_state_nxt = S_IDLE;
      end
      S_REQ: begin
        if (w_handshake || w_expire) w_state_nxt = S_RESP;
        else                         w_state_nxt = S_REQ;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the output registers; prdata is only non-zero during the RESP cycle.
  always_comb begin
    w_valid_nxt   = (w_state_nxt == S_REQ);
    w_busy_nxt    = (w_state_nxt != S_IDLE);
    w_pready_nxt  = w_handshake | w_expire;
    w_pslverr_nxt = w_expire;
    if (w_handshake) begin
      w_prdata_nxt = r_rwn ? cfg_rdata_i : 32'h0;
    end else if (w_expire) begin
      w_prdata_nxt = 32'hDEAD_0BAD;
    end else begin
      w_prdata_nxt = 32'h0;
    end
    if ((r_state == S_IDLE) && w_setup) begin
      w_addr_nxt  = w_paddr_ext[CFG_AWIDTH+1:2];
      w_wdata_nxt = apb_pwdata_i;
      w_rwn_nxt   = ~apb_pwrite_i;
    end else begin
      w_addr_nxt  = r_addr;
      w_wdata_nxt = r_wdata;
      w_rwn_nxt   = r_rwn;
    end
  end

  assign cfg_valid_o   = r_valid;
  assign cfg_addr_o    = r_addr;
  assign cfg_wdata_o   = r_wdata;
  assign cfg_rwn_o     = r_rwn;
  assign apb_prdata_o  = r_prdata;
  assign apb_pready_o  = r_pready;
  assign apb_pslverr_o = r_pslverr;
  assign busy_o        = r_busy;

endmodule
